// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU fetch/decode sequencer:
// FSM state encoding, opcode map constants and the decoded opcode class.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH_OP  = 3'd0,
        S_FETCH_ARG = 3'd1,
        S_EXECUTE   = 3'd2,
        S_EXEC_WAIT = 3'd3,
        S_HALTED    = 3'd4
    } fcu_state_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_JMP  = 8'h10;
    localparam logic [7:0] OP_JZ   = 8'h11;
    localparam logic [7:0] OP_HALT = 8'hFF;

    // ALU opcodes come in two bands: one-byte and two-byte (with operand)
    localparam logic [7:0] ALU1_LO = 8'h01;
    localparam logic [7:0] ALU1_HI = 8'h0F;
    localparam logic [7:0] ALU2_LO = 8'h20;
    localparam logic [7:0] ALU2_HI = 8'h3F;

    typedef struct packed {
        logic two_byte;
        logic is_alu;
        logic is_branch;
        logic is_halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: opcode -> {two_byte, is_alu, is_branch, is_halt, illegal}.
module opcode_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] opcode,
    output op_class_t         op_class
);

    logic nop, jmp, jz, halt, alu1, alu2;

    assign nop  = (opcode == DATA_W'(OP_NOP));
    assign jmp  = (opcode == DATA_W'(OP_JMP));
    assign jz   = (opcode == DATA_W'(OP_JZ));
    assign halt = (opcode == DATA_W'(OP_HALT));
    assign alu1 = (opcode >= DATA_W'(ALU1_LO)) && (opcode <= DATA_W'(ALU1_HI));
    assign alu2 = (opcode >= DATA_W'(ALU2_LO)) && (opcode <= DATA_W'(ALU2_HI));

    assign op_class.two_byte  = jmp | jz | alu2;
    assign op_class.is_alu    = alu1 | alu2;
    assign op_class.is_branch = jmp | jz;
    assign op_class.is_halt   = halt;
    assign op_class.illegal   = ~(nop | jmp | jz | halt | alu1 | alu2);

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch/decode sequencer driving program_counter and handing ALU ops to the datapath.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes jump to TRAP_VECTOR instead of acting as NOP.
module fetch_control_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'(8'hF0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] count,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic              zero_flag,
    input  logic              exec_ready,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              IncPC,
    output logic              LoadPC,
    output logic [ADDR_W-1:0] new_count,
    output logic              exec_valid,
    output logic [DATA_W-1:0] exec_op,
    output logic [DATA_W-1:0] exec_arg,
    output logic              halted
);

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    fcu_state_t        state;
    logic [DATA_W-1:0] ir_op;
    logic [DATA_W-1:0] ir_arg;
    logic [DATA_W-1:0] dec_in;
    op_class_t         dec;

    // In FETCH_OP the byte being fetched is classified to pick the next state;
    // everywhere else the latched opcode is what matters.
    assign dec_in = (state == S_FETCH_OP) ? mem_data : ir_op;

    opcode_decoder #(.DATA_W(DATA_W)) u_dec (
        .opcode   (dec_in),
        .op_class (dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_FETCH_OP;
            ir_op  <= '0;
            ir_arg <= '0;
        end else begin
            unique case (state)
                S_FETCH_OP: if (mem_ready) begin
                    ir_op  <= mem_data;
                    ir_arg <= '0;
                    state  <= dec.two_byte ? S_FETCH_ARG : S_EXECUTE;
                end
                S_FETCH_ARG: if (mem_ready) begin
                    ir_arg <= mem_data;
                    state  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (dec.is_alu)       state <= S_EXEC_WAIT;
                    else if (dec.is_halt) state <= S_HALTED;
                    else                  state <= S_FETCH_OP;
                end
                S_EXEC_WAIT: if (exec_ready) state <= S_FETCH_OP;
                S_HALTED:    state <= S_HALTED;
                default:     state <= S_FETCH_OP;
            endcase
        end
    end

    // Outputs decode from the state register; everything is forced low during reset.
    always_comb begin
        mem_rd     = 1'b0;
        mem_addr   = '0;
        IncPC      = 1'b0;
        LoadPC     = 1'b0;
        new_count  = '0;
        exec_valid = 1'b0;
        exec_op    = '0;
        exec_arg   = '0;
        halted     = 1'b0;
        if (reset) begin
            mem_addr = count;
            unique case (state)
                S_FETCH_OP, S_FETCH_ARG: begin
                    mem_rd = 1'b1;
                    IncPC  = mem_ready;
                end
                S_EXECUTE: begin
                    if (dec.is_branch && (ir_op == DATA_W'(OP_JMP) || zero_flag)) begin
                        LoadPC    = 1'b1;
                        new_count = ADDR_W'(ir_arg);
                    end else if (TRAP_EN && dec.illegal) begin
                        LoadPC    = 1'b1;
                        new_count = TRAP_VECTOR;
                    end
                end
                S_EXEC_WAIT: begin
                    exec_valid = 1'b1;
                    exec_op    = ir_op;
                    exec_arg   = ir_arg;
                end
                S_HALTED: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Self-checking bench for fetch_control_unit: decode table, hand-written corner
// sequences, and randomized programs checked against an instruction-level interpreter.
module tb_fetch_control_unit;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [7:0] TV = 8'hF0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] count;
    logic [7:0] mem_data;
    logic       mem_ready, zero_flag, exec_ready;
    logic       mem_rd, IncPC, LoadPC, exec_valid, halted;
    logic [7:0] mem_addr, new_count, exec_op, exec_arg;
    logic [7:0] mem [0:255];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .zero_flag  (zero_flag),
        .exec_ready (exec_ready),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .new_count  (new_count),
        .exec_valid (exec_valid),
        .exec_op    (exec_op),
        .exec_arg   (exec_arg),
        .halted     (halted)
    );

    // Instruction memory and a stand-in for program_counter
    assign mem_data = mem[mem_addr];

    always @(posedge clk) begin
        if (!reset)      count <= 8'h00;
        else if (LoadPC) count <= new_count;
        else if (IncPC)  count <= count + 8'h01;
    end

    typedef struct {
        bit inc, ld, rd, vld, hlt, rdy;
        logic [7:0] addr, nc, op, arg;
        logic [63:0] all;
    } obs_t;

    typedef struct {
        logic [7:0] op, arg;
        bit zf;
        int nb;
        bit exp_ld;
        logic [7:0] exp_nc;
        bit exp_ex;
        bit exp_next_seen;
        logic [7:0] exp_next;
        bit exp_hlt;
    } vec_t;

    typedef struct {
        int kind;
        logic [7:0] a, b;
    } ev_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; samples what the next posedge sees.
    task automatic tick(output obs_t o);
        #1;
        o.inc = IncPC;  o.ld = LoadPC;  o.rd = mem_rd;  o.vld = exec_valid;
        o.hlt = halted; o.rdy = exec_ready;
        o.addr = mem_addr; o.nc = new_count; o.op = exec_op; o.arg = exec_arg;
        o.all = {19'd0, mem_rd, mem_addr, IncPC, LoadPC, new_count, exec_valid,
                 exec_op, exec_arg, halted};
        @(negedge clk);
    endtask

    task automatic do_reset();
        obs_t o;
        reset = 1'b0; mem_ready = 1'b1; exec_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(o);
            chk("outputs low in reset", o.all, 64'd0);
        end
        reset = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        obs_t o;
        bit got_ld = 0, got_ex = 0, got_next = 0, got_h = 0;
        logic [7:0] ld_nc = 0, ex_op = 0, ex_arg = 0, nxt = 0;
        int incs = 0;
        clear_mem();
        mem[0] = v.op; mem[1] = v.arg; mem[TV] = 8'hFF;
        zero_flag = v.zf;
        do_reset();
        for (int c = 0; c < 12 && !got_next && !got_h; c++) begin
            tick(o);
            if (o.ld && !got_ld) begin got_ld = 1; ld_nc = o.nc; end
            if (o.vld && o.rdy) begin got_ex = 1; ex_op = o.op; ex_arg = o.arg; end
            if (o.inc) begin
                incs++;
                if (incs == v.nb + 1) begin got_next = 1; nxt = o.addr; end
            end
            if (o.hlt) got_h = 1;
        end
        chk($sformatf("vec%0d op%02h load", idx, v.op), {got_ld, ld_nc}, {v.exp_ld, v.exp_nc});
        chk($sformatf("vec%0d op%02h exec", idx, v.op), {got_ex, ex_op, ex_arg},
            {v.exp_ex, v.exp_ex ? v.op : 8'h00, (v.exp_ex && v.nb == 2) ? v.arg : 8'h00});
        chk($sformatf("vec%0d op%02h next fetch", idx, v.op), {got_next, nxt},
            {v.exp_next_seen, v.exp_next});
        chk($sformatf("vec%0d op%02h halted", idx, v.op), got_h, v.exp_hlt);
    endtask

    // Instruction-level interpreter producing the expected event stream:
    // 0 = fetch at addr, 1 = PC load, 2 = exec handoff, 3 = halt.
    task automatic interpret(input bit zf, output ev_t q[$]);
        logic [7:0] pc, op, arg;
        bit two, alu;
        q = {};
        pc = 8'h00;
        for (int k = 0; k < 30; k++) begin
            op = mem[pc]; q.push_back('{0, pc, 8'h00}); pc = pc + 8'h01;
            two = (op == 8'h10) || (op == 8'h11) || (op >= 8'h20 && op <= 8'h3F);
            alu = (op >= 8'h01 && op <= 8'h0F) || (op >= 8'h20 && op <= 8'h3F);
            arg = 8'h00;
            if (two) begin arg = mem[pc]; q.push_back('{0, pc, 8'h00}); pc = pc + 8'h01; end
            if (op == 8'hFF) begin q.push_back('{3, 8'h00, 8'h00}); break; end
            if (op == 8'h10 || (op == 8'h11 && zf)) begin q.push_back('{1, arg, 8'h00}); pc = arg; end
            else if (alu) q.push_back('{2, op, arg});
            else if (op != 8'h00 && op != 8'h11 && TRAP) begin q.push_back('{1, TV, 8'h00}); pc = TV; end
        end
    endtask

    function automatic logic [7:0] rand_byte_op();
        int r = $urandom_range(0, 99);
        if (r < 30) return 8'($urandom_range(1, 15));
        if (r < 45) return 8'($urandom_range(32, 63));
        if (r < 55) return 8'h11;
        if (r < 62) return 8'h10;
        if (r < 72) return 8'h00;
        if (r < 80) return 8'($urandom_range(64, 254));
        if (r < 82) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic random_run(input int run);
        obs_t o;
        ev_t exp_q[$], obs_q[$];
        bit pv = 0, pr = 0, seen_h = 0;
        logic [7:0] pop = 0, parg = 0;
        int cyc = 0;
        for (int i = 0; i < 256; i++) mem[i] = rand_byte_op();
        zero_flag = 1'($urandom_range(0, 1));
        interpret(zero_flag, exp_q);
        do_reset();
        while (obs_q.size() < exp_q.size() && cyc < 2000) begin
            mem_ready  = ($urandom_range(0, 3) != 0);
            exec_ready = ($urandom_range(0, 3) != 0);
            tick(o);
            cyc++;
            chk("IncPC/LoadPC exclusive", {o.inc, o.ld} == 2'b11, 1'b0);
            if (!o.ld) chk("new_count idle zero", o.nc, 8'h00);
            if (pv && !pr) chk("exec_valid held stable", {o.vld, o.op, o.arg}, {1'b1, pop, parg});
            pv = o.vld; pr = o.rdy; pop = o.op; parg = o.arg;
            if (o.inc) obs_q.push_back('{0, o.addr, 8'h00});
            if (o.ld)  obs_q.push_back('{1, o.nc, 8'h00});
            if (o.vld && o.rdy) obs_q.push_back('{2, o.op, o.arg});
            if (o.hlt && !seen_h) begin seen_h = 1; obs_q.push_back('{3, 8'h00, 8'h00}); end
        end
        chk($sformatf("rand%0d event count", run), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("rand%0d event %0d", run, i),
                {obs_q[i].kind[7:0], obs_q[i].a, obs_q[i].b},
                {exp_q[i].kind[7:0], exp_q[i].a, exp_q[i].b});
    endtask

    initial begin
        obs_t o;
        vec_t vecs[$];
        reset = 1'b0; mem_ready = 1'b1; exec_ready = 1'b1; zero_flag = 1'b0;
        clear_mem();
        @(negedge clk);

        // Reset, then first fetch from address 0
        do_reset();
        tick(o);
        chk("first fetch rd/addr/inc", {o.rd, o.addr, o.inc}, {1'b1, 8'h00, 1'b1});

        //          op     arg    zf nb ld     nc                    ex seen next                   hlt
        vecs.push_back('{8'h00, 8'hAA, 0, 1, 0,    8'h00,                0, 1, 8'h01,               0});
        vecs.push_back('{8'h05, 8'hAA, 0, 1, 0,    8'h00,                1, 1, 8'h01,               0});
        vecs.push_back('{8'h0F, 8'hAA, 1, 1, 0,    8'h00,                1, 1, 8'h01,               0});
        vecs.push_back('{8'h10, 8'h40, 0, 2, 1,    8'h40,                0, 1, 8'h40,               0});
        vecs.push_back('{8'h11, 8'h20, 0, 2, 0,    8'h00,                0, 1, 8'h02,               0});
        vecs.push_back('{8'h11, 8'h20, 1, 2, 1,    8'h20,                0, 1, 8'h20,               0});
        vecs.push_back('{8'h20, 8'hA5, 0, 2, 0,    8'h00,                1, 1, 8'h02,               0});
        vecs.push_back('{8'h3F, 8'h01, 0, 2, 0,    8'h00,                1, 1, 8'h02,               0});
        vecs.push_back('{8'h12, 8'h55, 0, 1, TRAP, TRAP ? TV : 8'h00,    0, 1, TRAP ? TV : 8'h01,   0});
        vecs.push_back('{8'h1F, 8'h55, 1, 1, TRAP, TRAP ? TV : 8'h00,    0, 1, TRAP ? TV : 8'h01,   0});
        vecs.push_back('{8'h40, 8'h55, 0, 1, TRAP, TRAP ? TV : 8'h00,    0, 1, TRAP ? TV : 8'h01,   0});
        vecs.push_back('{8'hFE, 8'h55, 0, 1, TRAP, TRAP ? TV : 8'h00,    0, 1, TRAP ? TV : 8'h01,   0});
        vecs.push_back('{8'hFF, 8'h55, 0, 1, 0,    8'h00,                0, 0, 8'h00,               1});
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // 1-byte ALU op with no stalls completes in three cycles
        clear_mem(); mem[0] = 8'h05; zero_flag = 1'b0;
        do_reset();
        tick(o); chk("lat c1 fetch", {o.inc, o.vld}, 2'b10);
        tick(o); chk("lat c2 execute", {o.inc, o.vld, o.rd}, 3'b000);
        tick(o); chk("lat c3 exec_valid", o.vld, 1'b1);
        tick(o); chk("lat c4 next fetch", {o.rd, o.inc, o.addr}, {2'b11, 8'h01});

        // Back-pressure: exec_ready low for 3 cycles
        clear_mem(); mem[0] = 8'h25; mem[1] = 8'hA5;
        do_reset();
        exec_ready = 1'b0;
        tick(o); chk("bp fetch op", {o.inc, o.addr}, {1'b1, 8'h00});
        tick(o); chk("bp fetch arg", {o.inc, o.addr}, {1'b1, 8'h01});
        tick(o); chk("bp execute", {o.inc, o.ld, o.vld}, 3'b000);
        for (int i = 0; i < 4; i++) begin
            exec_ready = (i == 3);
            tick(o);
            chk($sformatf("bp wait %0d", i), {o.vld, o.op, o.arg, o.inc, o.ld},
                {1'b1, 8'h25, 8'hA5, 2'b00});
        end
        exec_ready = 1'b1;
        tick(o); chk("bp released", {o.vld, o.rd, o.addr}, {2'b01, 8'h02});

        // Memory wait states, then reset during EXEC_WAIT
        clear_mem(); mem[0] = 8'h05;
        do_reset();
        mem_ready = 1'b0;
        tick(o); chk("mw stall 1", {o.rd, o.inc, o.addr}, {2'b10, 8'h00});
        tick(o); chk("mw stall 2", {o.rd, o.inc, o.addr}, {2'b10, 8'h00});
        mem_ready = 1'b1;
        tick(o); chk("mw ready", {o.rd, o.inc}, 2'b11);
        exec_ready = 1'b0;
        tick(o); chk("mw execute", {o.rd, o.inc}, 2'b00);
        tick(o); chk("mw exec_valid", o.vld, 1'b1);
        reset = 1'b0;
        tick(o); chk("mw reset outputs", o.all, 64'd0);
        reset = 1'b1; exec_ready = 1'b1;
        tick(o); chk("mw after reset", {o.rd, o.addr, o.inc, o.vld}, {1'b1, 8'h00, 2'b10});

        // Illegal opcode then HALT
        clear_mem(); mem[0] = 8'h80; mem[1] = 8'hFF; mem[TV] = 8'hFF;
        do_reset();
        tick(o); chk("ill fetch", {o.inc, o.addr}, {1'b1, 8'h00});
        tick(o); chk("ill execute", {o.ld, o.nc}, {TRAP, TRAP ? TV : 8'h00});
        tick(o); chk("halt fetch", {o.inc, o.addr}, {1'b1, TRAP ? TV : 8'h01});
        tick(o); chk("halt execute", {o.ld, o.inc, o.hlt}, 3'b000);
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            tick(o);
            chk($sformatf("halted %0d", i), {o.hlt, o.rd, o.inc, o.ld}, 4'b1000);
        end

        for (int r = 0; r < 8; r++) random_run(r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_control_unit.md
Name: fetch_control_unit

Overview:
- Fetch/decode sequencer for the 8-bit CPU, directly upstream of program_counter.
- Reads program bytes from instruction memory at the current PC (count), latches opcode/operand, and drives program_counter's IncPC, LoadPC and new_count.
- Hands non-branch instructions to the datapath over a valid/ready handshake.

Parameters:
ADDR_W, 8, PC / memory address width (matches program_counter count width)
DATA_W, 8, instruction memory byte width
TRAP_VECTOR, 8'hF0, PC target for illegal opcodes (used only with ILLEGAL_TRAP_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
count  input  ADDR_W  current PC from program_counter
mem_data  input  DATA_W  instruction memory read data
mem_ready  input  1  mem_data valid this cycle for the outstanding read
zero_flag  input  1  datapath zero flag, sampled in EXECUTE
exec_ready  input  1  datapath accepts the current exec op
mem_rd  output  1  read request, held until mem_ready
mem_addr  output  ADDR_W  read address (= count)
IncPC  output  1  one-cycle increment pulse to program_counter
LoadPC  output  1  one-cycle load pulse to program_counter
new_count  output  ADDR_W  load value for program_counter
exec_valid  output  1  exec_op/exec_arg valid
exec_op  output  DATA_W  latched opcode
exec_arg  output  DATA_W  latched operand (0 for 1-byte ops)
halted  output  1  high in HALTED state

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low. While reset=0 at a rising edge: state<=FETCH_OP, ir_op/ir_arg<=0. While reset is low, all outputs are 0. Reset mid-handshake abandons the read or exec with no PC pulse.
- States: FETCH_OP, FETCH_ARG, EXECUTE, EXEC_WAIT, HALTED.
- FETCH_OP: mem_rd=1, mem_addr=count. On the cycle mem_ready=1, IncPC=1 (Mealy) and ir_op<=mem_data.
  - Next state is FETCH_ARG for 2-byte ops, else EXECUTE.
  - Next cycle count is already incremented.
- FETCH_ARG: same read and IncPC rule; ir_arg<=mem_data; next state EXECUTE. 1-byte ops clear ir_arg to 0.
- Opcode map:
  - 8'h00 NOP (1B)
  - 8'h01-8'h0F ALU (1B)
  - 8'h10 JMP (2B)
  - 8'h11 JZ (2B)
  - 8'h20-8'h3F ALU (2B)
  - 8'hFF HALT (1B)
  - all others illegal (1B)
- EXECUTE, one cycle:
  - NOP: go to FETCH_OP.
  - JMP: LoadPC=1, new_count=ir_arg, go to FETCH_OP.
  - JZ: LoadPC=zero_flag, new_count=ir_arg, go to FETCH_OP.
  - ALU: go to EXEC_WAIT.
  - HALT: go to HALTED.
- EXEC_WAIT: exec_valid=1, exec_op/exec_arg stable. On exec_valid and exec_ready, go to FETCH_OP. exec_valid never deasserts before acceptance.
- HALTED: absorbing; only reset exits. mem_rd=0.
- Invariants:
  - IncPC and LoadPC are never both 1.
  - new_count=0 when LoadPC=0.
  - PC wrap-around (8'hFF to 8'h00) is program_counter's concern. A fetch at 8'hFF simply proceeds.
- Latency: 1-byte ALU op with zero-wait memory and exec_ready=1 takes 3 cycles (FETCH_OP, EXECUTE, EXEC_WAIT).

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in EXECUTE drives LoadPC=1, new_count=TRAP_VECTOR, then FETCH_OP.
- Undefined: an illegal opcode executes as NOP.

Decomposition:
- Package cpu_pkg: state enum encoding, opcode constants (OP_NOP, OP_JMP, OP_JZ, OP_HALT, ALU range bounds), and is_two_byte/is_alu/is_illegal decode constants.
- One natural sub-module: opcode_decoder, combinational, giving opcode -> {two_byte, is_alu, is_branch, is_halt, illegal}.

Test Plan:
1. Reset low two cycles, then high, with memory returning 8'h00 and mem_ready=1 -> all outputs 0 during reset; first cycle after, mem_rd=1, mem_addr=8'h00, IncPC=1.
2. Program {8'h10, 8'h40} at 0 -> two IncPC pulses, then LoadPC=1 with new_count=8'h40; next fetch at mem_addr=8'h40.
3. Program {8'h11, 8'h20}:
   - zero_flag=0 -> no LoadPC; next fetch at 8'h02.
   - zero_flag=1 -> LoadPC, new_count=8'h20.
4. Program {8'h25, 8'hA5} with exec_ready held low 3 cycles -> exec_valid high 4 cycles, exec_op=8'h25, exec_arg=8'hA5, no PC pulses meanwhile.
5. mem_ready delayed 2 cycles on opcode fetch, then reset asserted during EXEC_WAIT -> mem_rd held 3 cycles, single IncPC; after reset, state FETCH_OP, exec_valid=0.
6. Opcode 8'h80, then 8'hFF:
   - With ILLEGAL_TRAP_EN: LoadPC with new_count=8'hF0.
   - Without: NOP, then HALT -> halted=1, mem_rd=0 indefinitely.
